// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern_tx serial frame transmitter and its detector.
package pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_t;

    localparam int         SYNC_LEN_DEF     = 4;
    localparam logic [3:0] SYNC_PATTERN_DEF = 4'b0110;

    // Counter must hold max(a,b)-1; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out shift register, MSB first, zero fill on shift.
module piso_shreg
    import pattern_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] shreg_r;

    // Load has priority over shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= '0;
        end else if (load) begin
            shreg_r <= din;
        end else if (shift_en) begin
            shreg_r <= shreg_r << 1'b1;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign msb = shreg_r[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial frame transmitter: sync pattern then payload MSB-first on a registered line.
// Optional even-parity trailer bit enabled by defining PATTERN_TX_PARITY_EN.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int                  DATA_W       = 8,
    parameter int                  SYNC_LEN     = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter logic                IDLE_LEVEL   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int                  CNT_W     = cnt_width(SYNC_LEN, DATA_W);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_W - 1);
    // The first sync bit goes straight to the line, so the register holds only the rest.
    localparam logic [SYNC_LEN-1:0] SYNC_REST = SYNC_PATTERN << 1'b1;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              out_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_s;
    logic              cnt_zero_s;
    logic              sync_shift_s;
    logic              data_shift_s;
    logic              sync_msb_s;
    logic              data_msb_s;

    // Shift enables: each register advances on the edge that puts its next bit on the line.
    always_comb begin
        accept_s     = 1'b0;
        cnt_zero_s   = (cnt_r == '0);
        sync_shift_s = 1'b0;
        data_shift_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = valid_in;
        end else if (state_r == ST_SYNC) begin
            sync_shift_s = !cnt_zero_s;
            data_shift_s = cnt_zero_s;
        end else if (state_r == ST_DATA) begin
            data_shift_s = !cnt_zero_s;
        end else begin
            accept_s = 1'b0;
        end
    end

    piso_shreg #(.W(SYNC_LEN)) u_sync_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .shift_en (sync_shift_s),
        .din      (SYNC_REST),
        .msb      (sync_msb_s)
    );

    piso_shreg #(.W(DATA_W)) u_data_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .shift_en (data_shift_s),
        .din      (data_in),
        .msb      (data_msb_s)
    );

`ifdef PATTERN_TX_PARITY_EN
    logic par_r;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Parity is captured with the word so later data_in changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else if (accept_s) begin
            par_r <= even_parity(data_in);
        end else begin
            par_r <= par_r;
        end
    end
`endif

    // Frame FSM; the line value is computed one edge ahead so out is a plain flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            out_r   <= IDLE_LEVEL;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (valid_in) begin
                        state_r <= ST_SYNC;
                        cnt_r   <= SYNC_LAST;
                        out_r   <= SYNC_PATTERN[SYNC_LEN-1];
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        out_r   <= IDLE_LEVEL;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_DATA;
                        cnt_r   <= DATA_LAST;
                        out_r   <= data_msb_s;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        out_r   <= sync_msb_s;
                    end
                end
                ST_DATA: begin
                    if (!cnt_zero_s) begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        out_r   <= data_msb_s;
                    end else begin
`ifdef PATTERN_TX_PARITY_EN
                        state_r <= ST_PAR;
                        out_r   <= par_r;
`else
                        state_r <= ST_IDLE;
                        out_r   <= IDLE_LEVEL;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`endif
                    end
                end
`ifdef PATTERN_TX_PARITY_EN
                ST_PAR: begin
                    state_r <= ST_IDLE;
                    out_r   <= IDLE_LEVEL;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    out_r   <= IDLE_LEVEL;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_r;
    assign ready_out = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed self-checking bench for pattern_tx (default build and PATTERN_TX_PARITY_EN).
module tb_pattern_tx;

`ifdef PATTERN_TX_PARITY_EN
    localparam int FLEN = 13;
`else
    localparam int FLEN = 12;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [7:0] data_in;
    logic       out;
    logic       ready_out;
    logic       busy;
    logic       done;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] hist;

    pattern_tx dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"},   {7'd0, out},       8'd1);
        chk({tag, "_ready"}, {7'd0, ready_out}, 8'd1);
        chk({tag, "_busy"},  {7'd0, busy},      8'd0);
        chk({tag, "_done"},  {7'd0, done},      8'd0);
    endtask

    // Called in cycle 1 of a frame; ends in the done cycle after the last bit.
    task automatic run_frame(input string tag, input logic [11:0] bits, input logic par,
                             input int chg_cyc, input logic [7:0] chg_data);
        logic [12:0] exp;
        exp  = {bits, par};
        hist = 4'b0000;
        for (int i = 1; i <= FLEN; i++) begin
            chk($sformatf("%s_out_c%0d", tag, i), {7'd0, out}, {7'd0, exp[13-i]});
            chk($sformatf("%s_busy_c%0d", tag, i), {7'd0, busy}, 8'd1);
            chk($sformatf("%s_ready_c%0d", tag, i), {7'd0, ready_out}, 8'd0);
            chk($sformatf("%s_done_c%0d", tag, i), {7'd0, done}, 8'd0);
            hist = {hist[2:0], out};
            if (i == 4) begin
                chk({tag, "_detect"}, {4'd0, hist}, 8'h06);
            end
            if (i == chg_cyc) begin
                data_in = chg_data;
            end
            tick();
        end
        chk({tag, "_done_pulse"}, {7'd0, done},      8'd1);
        chk({tag, "_done_ready"}, {7'd0, ready_out}, 8'd1);
        chk({tag, "_done_busy"},  {7'd0, busy},      8'd0);
        chk({tag, "_gap_out"},    {7'd0, out},       8'd1);
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        hist     = 4'b0000;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle($sformatf("idle_%0d", i));
        end

        // Single frame A5
        data_in  = 8'hA5;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        run_frame("a5", 12'b0110_1010_0101, 1'b0, 0, 8'h00);
        tick();
        chk("a5_done_once", {7'd0, done}, 8'd0);
        chk("a5_idle_out",  {7'd0, out},  8'd1);

        // Back-to-back FF then 00 with valid held high
        data_in  = 8'hFF;
        valid_in = 1'b1;
        tick();
        data_in  = 8'h00;
        run_frame("ff", 12'b0110_1111_1111, 1'b0, 0, 8'h00);
        tick();
        valid_in = 1'b0;
        run_frame("b2b00", 12'b0110_0000_0000, 1'b0, 0, 8'h00);
        tick();

        // Mid-frame reset on 3C
        data_in  = 8'h3C;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("rstmid_c6_out",  {7'd0, out},  8'd0);
        chk("rstmid_c6_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rstmid_c7");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("rstmid_after_%0d", i));
        end
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        run_frame("3c", 12'b0110_0011_1100, 1'b0, 0, 8'h00);
        tick();

        // Input change while busy: 81 latched, 7E applied in cycle 3
        data_in  = 8'h81;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        run_frame("81", 12'b0110_1000_0001, 1'b0, 3, 8'h7E);
        tick();

        // 07 has three ones: parity bit 1 when the trailer is built in
        data_in  = 8'h07;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        run_frame("07", 12'b0110_0000_0111, 1'b1, 0, 8'h00);
        tick();

        // Reset and valid together: the word is dropped
        data_in  = 8'hAA;
        valid_in = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        chk_idle("rstvalid");
        tick();
        chk_idle("rstvalid_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
- Serial frame transmitter that drives the single-bit line read by the team's "0110" sequence detector.
- On a valid/ready handshake it emits the 4-bit sync pattern 0110, then a DATA_W-bit payload MSB-first, one bit per clock.
- The line then returns to the idle-high level.
- Sits between a parallel word producer and the serial `in` of the detector FSM.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- SYNC_LEN, 4, number of sync bits (>=1).
- SYNC_PATTERN, 4'b0110, sync bits sent MSB-first; width SYNC_LEN.
- IDLE_LEVEL, 1'b1, line level when not transmitting.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  payload word, sampled on handshake.
- valid_in  input  1  producer has a word.
- ready_out  output  1  transmitter can accept a word (high only in IDLE).
- out  output  1  serial line, registered.
- busy  output  1  frame in progress (SYNC/DATA/PAR states).
- done  output  1  one-cycle pulse after the last frame bit.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values: out=IDLE_LEVEL, ready_out=1, busy=0, done=0, state=IDLE, counter=0, shift register=0.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- States: IDLE, SYNC, DATA, PAR (PAR exists only with the optional feature).
- IDLE:
  - out=IDLE_LEVEL, ready_out=1.
  - If valid_in=1 at an edge, latch data_in into the payload shift register, load SYNC_PATTERN into the sync register, set counter=SYNC_LEN-1, and go to SYNC.
  - If valid_in=0, stay in IDLE.
- SYNC:
  - out = current sync MSB; shift left each cycle; counter decrements.
  - When counter=0, load counter=DATA_W-1 and go to DATA.
- DATA:
  - out = current payload MSB; shift left each cycle.
  - When counter=0, go to PAR if enabled, otherwise IDLE.
- Latency: handshake at edge k puts the first sync bit on out in cycle k+1.
  - Frame occupies SYNC_LEN+DATA_W cycles (+1 with parity). Default is 12 cycles.
- done=1 for exactly the first IDLE cycle after a completed frame.
  - ready_out is also 1 in that cycle, so a back-to-back word can be accepted.
  - Minimum inter-frame gap is one IDLE_LEVEL cycle.
- valid_in or data_in changing while busy is ignored; the latched word is sent intact.
- Reset mid-frame: the frame is aborted. Next cycle out=IDLE_LEVEL, done=0, ready_out=1.
- rst and valid_in high together: reset wins and the word is not accepted.
- Counter width is $clog2(max(SYNC_LEN,DATA_W)) bits, minimum 1. It must never wrap below 0.
- Known limitation: a payload containing 0110 can false-trigger the detector. No bit-stuffing is performed.

Optional Feature:
- Macro PATTERN_TX_PARITY_EN.
- When defined:
  - After the last data bit, state PAR drives one even-parity bit (XOR of all DATA_W payload bits) for one cycle, then goes to IDLE.
  - Frame length is SYNC_LEN+DATA_W+1 cycles.
  - done follows the parity cycle.
- When undefined:
  - PAR state and its parity logic are absent.
  - DATA goes directly to IDLE.

Decomposition:
- Package pattern_pkg holds:
  - State encodings ST_IDLE=2'd0, ST_SYNC=2'd1, ST_DATA=2'd2, ST_PAR=2'd3.
  - Default SYNC_PATTERN/SYNC_LEN constants shared with the detector.
- Sub-module piso_shreg: parameterised parallel-in/serial-out shift register with load, shift-enable and MSB output.
  - Instantiated once for the payload.
  - The sync pattern uses a small local register or a second instance.

Test Plan:
- Reset then idle: rst high 2 cycles, then valid_in=0 for 10 cycles -> out=1, ready_out=1, busy=0, done=0 throughout.
- Single frame: data_in=8'hA5, valid_in pulse at edge 0 -> out cycles 1..12 = 0,1,1,0,1,0,1,0,0,1,0,1; done=1 in cycle 13; busy high cycles 1..12.
- Back-to-back: valid_in held high with 8'hFF then 8'h00 -> second sync starts cycle 14 after a single out=1 gap cycle; ready_out low cycles 1..12 and 14..25.
- Mid-frame reset: send 8'h3C, assert rst in cycle 6 -> cycle 7 out=1, ready_out=1, no done pulse; next frame is transmitted correctly.
- Input change while busy: send 8'h81, change data_in to 8'h7E in cycle 3 -> payload bits remain 1,0,0,0,0,0,0,1.
- With PATTERN_TX_PARITY_EN: data_in=8'h07 -> cycle 13 out=1 (odd count of ones), done in cycle 14; loop the output into the detector and check it asserts after the sync.
